flash_loader: RTL and testbench

- Boot-time copier: reads a contiguous image from SPI flash (read command 0x03) and writes it into RAM as 32-bit words through the RAMIO request interface.
- Sits upstream of RAMIO, in place of the core during boot. Asserts done once the image is resident, after which the core may start fetching.

---
 rtl/flash_loader_pkg.sv | 21 ++
 rtl/flash_loader_if.sv | 32 +++
 rtl/flash_loader_spi_shifter.sv | 90 +++++++++
 rtl/flash_loader.sv | 178 +++++++++++++++++
 tb/tb_flash_loader.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time SPI flash to RAMIO copier.
package flash_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CS_ASSERT,
        SEND_CMD,
        SEND_ADDR,
        READ_BYTE,
        WRITE_REQ,
        WRITE_WAIT,
        FINISH,
        DONE
    } state_t;

    localparam logic [7:0] FLASH_CMD_READ  = 8'h03;
    localparam logic [1:0] WRITE_TYPE_WORD = 2'b11;
    localparam logic [1:0] WRITE_TYPE_NONE = 2'b00;
    localparam logic [2:0] READ_TYPE_NONE  = 3'b000;

endpackage

// File: rtl/flash_loader_if.sv
// Flash SPI pins and RAMIO request bus; master is the loader, slave is the memory side.
interface flash_loader_if;

    logic        flash_clk;
    logic        flash_miso;
    logic        flash_mosi;
    logic        flash_cs;

    logic        ramio_enable;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address;
    logic [31:0] ramio_data_in;
    logic        ramio_busy;

    modport master (
        output flash_clk, flash_mosi, flash_cs,
        input  flash_miso,
        output ramio_enable, ramio_write_type, ramio_read_type,
        output ramio_address, ramio_data_in,
        input  ramio_busy
    );

    modport slave (
        input  flash_clk, flash_mosi, flash_cs,
        output flash_miso,
        input  ramio_enable, ramio_write_type, ramio_read_type,
        input  ramio_address, ramio_data_in,
        output ramio_busy
    );

endinterface

// File: rtl/flash_loader_spi_shifter.sv
// Mode-0 SPI bit engine: two clk cycles per bit, MSB-first TX from a left-aligned
// 24-bit word and an 8-bit RX register; done pulses one cycle after the last bit.
module flash_loader_spi_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  num_bits,
    input  logic [23:0] tx_data,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [7:0]  rx_data
);

    logic        active_q, active_d;
    logic        phase_q, phase_d;
    logic [4:0]  bits_left_q, bits_left_d;
    logic [23:0] shreg_q, shreg_d;
    logic [7:0]  rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        done_q, done_d;

    // Phase 0 presents the next MOSI bit with SCK low; the edge that ends phase 1
    // samples MISO and drops SCK again.
    always_comb begin
        active_d    = active_q;
        phase_d     = phase_q;
        bits_left_d = bits_left_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        done_d      = 1'b0;
        if (!active_q) begin
            if (start) begin
                active_d    = 1'b1;
                phase_d     = 1'b0;
                bits_left_d = num_bits;
                mosi_d      = tx_data[23];
                shreg_d     = {tx_data[22:0], 1'b0};
                sck_d       = 1'b0;
            end
        end else if (!phase_q) begin
            phase_d = 1'b1;
            sck_d   = 1'b1;
        end else begin
            rx_d    = {rx_q[6:0], miso};
            sck_d   = 1'b0;
            phase_d = 1'b0;
            if (bits_left_q == 5'd1) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                bits_left_d = bits_left_q - 5'd1;
                mosi_d      = shreg_q[23];
                shreg_d     = {shreg_q[22:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= 1'b0;
            phase_q     <= 1'b0;
            bits_left_q <= 5'd0;
            shreg_q     <= 24'h0;
            rx_q        <= 8'h0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            active_q    <= active_d;
            phase_q     <= phase_d;
            bits_left_q <= bits_left_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign done    = done_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/flash_loader.sv
// Boot copier: streams TRANSFER_BYTES_NUM bytes from SPI flash (READ 0x03) into RAM
// as little-endian 32-bit words through RAMIO, then holds done until the next start.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int          TRANSFER_BYTES_NUM = 4096,
    parameter logic [23:0] FLASH_START_ADDR   = 24'h00_0000,
    parameter logic [31:0] RAM_START_ADDR     = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    flash_loader_if.master    bus
);

    localparam int CNT_W = $clog2(TRANSFER_BYTES_NUM) + 1;

    if ((TRANSFER_BYTES_NUM <= 0) || ((TRANSFER_BYTES_NUM % 4) != 0)) begin : g_bad_transfer_size
        $error("flash_loader: TRANSFER_BYTES_NUM must be a nonzero multiple of 4");
    end

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cs_q, cs_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               wait_armed_q, wait_armed_d;

    logic               spi_start;
    logic [4:0]         spi_bits;
    logic [23:0]        spi_tx;
    logic               spi_done;
    logic [7:0]         spi_rx;
    logic               spi_sck;
    logic               spi_mosi;
    logic               ram_req;

    flash_loader_spi_shifter u_spi_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (spi_start),
        .num_bits (spi_bits),
        .tx_data  (spi_tx),
        .miso     (bus.flash_miso),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .done     (spi_done),
        .rx_data  (spi_rx)
    );

    // The write request is gated by the live ramio_busy so a request can never be
    // issued into a busy RAMIO, even for a single cycle.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        cs_d         = cs_q;
        addr_d       = addr_q;
        data_d       = data_q;
        byte_cnt_d   = byte_cnt_q;
        wait_armed_d = wait_armed_q;
        spi_start    = 1'b0;
        spi_bits     = 5'd8;
        spi_tx       = 24'h0;
        ram_req      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = CS_ASSERT;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cs_d       = 1'b0;
                    addr_d     = RAM_START_ADDR;
                    data_d     = 32'h0;
                    byte_cnt_d = '0;
                end
            end
            CS_ASSERT: begin
                spi_start = 1'b1;
                spi_tx    = {FLASH_CMD_READ, 16'h0000};
                state_d   = SEND_CMD;
            end
            SEND_CMD: begin
                if (spi_done) begin
                    spi_start = 1'b1;
                    spi_bits  = 5'd24;
                    spi_tx    = FLASH_START_ADDR;
                    state_d   = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                if (spi_done) begin
                    spi_start = 1'b1;
                    state_d   = READ_BYTE;
                end
            end
            READ_BYTE: begin
                if (spi_done) begin
                    data_d[{byte_cnt_q[1:0], 3'b000} +: 8] = spi_rx;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q[1:0] == 2'd3) begin
                        state_d      = WRITE_REQ;
                        wait_armed_d = 1'b0;
                    end else begin
                        spi_start = 1'b1;
                    end
                end
            end
            WRITE_REQ: begin
                if (!bus.ramio_busy) begin
                    ram_req      = 1'b1;
                    state_d      = WRITE_WAIT;
                    wait_armed_d = 1'b0;
                end
            end
            WRITE_WAIT: begin
                // The first cycle is skipped because RAMIO may raise busy one cycle late.
                if (!wait_armed_q) begin
                    wait_armed_d = 1'b1;
                end else if (!bus.ramio_busy) begin
                    wait_armed_d = 1'b0;
                    addr_d       = addr_q + 32'd4;
                    if (byte_cnt_q == CNT_W'(TRANSFER_BYTES_NUM)) begin
                        cs_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        spi_start = 1'b1;
                        state_d   = READ_BYTE;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cs_q         <= 1'b1;
            addr_q       <= RAM_START_ADDR;
            data_q       <= 32'h0;
            byte_cnt_q   <= '0;
            wait_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cs_q         <= cs_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_cnt_q   <= byte_cnt_d;
            wait_armed_q <= wait_armed_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign bus.flash_clk        = spi_sck;
    assign bus.flash_mosi       = spi_mosi;
    assign bus.flash_cs         = cs_q;
    assign bus.ramio_enable     = ram_req;
    assign bus.ramio_write_type = ram_req ? WRITE_TYPE_WORD : WRITE_TYPE_NONE;
    assign bus.ramio_read_type  = READ_TYPE_NONE;
    assign bus.ramio_address    = addr_q;
    assign bus.ramio_data_in    = data_q;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: behavioural SPI flash and RAMIO models, with expected RAM
// writes queued at start and checked as each RAMIO request appears.
module tb_flash_loader;

    localparam int          XFER       = 32;
    localparam int          WORDS      = XFER / 4;
    localparam logic [23:0] FLASH_BASE = 24'h00_0040;
    localparam logic [31:0] RAM_BASE   = 32'h0000_0200;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    flash_loader_if bus ();

    flash_loader #(
        .TRANSFER_BYTES_NUM (XFER),
        .FLASH_START_ADDR   (FLASH_BASE),
        .RAM_START_ADDR     (RAM_BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wr_t         exp_q[$];
    logic [7:0]  flash_mem [0:255];
    logic [31:0] ram_mem [0:WORDS-1];
    int          writes_seen = 0;
    int          busy_falls = 0;

    int   ram_lat = 0;
    int   lat_rem = 0;
    bit   lat_kick = 0;
    logic force_busy = 1'b0;
    logic lat_busy = 1'b0;

    int          fl_bits = 0;
    logic [31:0] fl_shift = 32'h0;
    logic [7:0]  hdr_cmd = 8'h00;
    logic [23:0] hdr_addr = 24'h0;
    logic        miso_r = 1'b0;

    assign bus.ramio_busy = force_busy | lat_busy;
    assign bus.flash_miso = miso_r;

    always @(negedge busy) busy_falls++;

    // SPI flash: command and address captured on rising SCK, data driven on falling SCK.
    always @(posedge bus.flash_cs) fl_bits = 0;

    always @(posedge bus.flash_clk) begin
        if (bus.flash_cs === 1'b0) begin
            if (fl_bits < 32) fl_shift = {fl_shift[30:0], bus.flash_mosi};
            fl_bits++;
            if (fl_bits == 32) begin
                hdr_cmd  = fl_shift[31:24];
                hdr_addr = fl_shift[23:0];
            end
        end
    end

    always @(negedge bus.flash_clk) begin
        if (bus.flash_cs === 1'b0 && fl_bits >= 32) begin
            int idx;
            logic [7:0] b;
            idx    = fl_bits - 32;
            b      = flash_mem[(int'(hdr_addr) + idx / 8) % 256];
            miso_r = b[7 - (idx % 8)];
        end
    end

    // RAMIO: requests observed mid-cycle, busy updated just after the rising edge.
    always begin
        wr_t e;
        logic [31:0] off;
        @(negedge clk);
        if (rst === 1'b0 && bus.ramio_enable === 1'b1) begin
            writes_seen++;
            checks++;
            if (bus.ramio_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL enable_while_busy: busy=%b required 0", bus.ramio_busy);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: addr=%h data=%h, no write required", bus.ramio_address, bus.ramio_data_in);
            end else begin
                e = exp_q.pop_front();
                if ({bus.ramio_write_type, bus.ramio_read_type, bus.ramio_address, bus.ramio_data_in} !== {2'b11, 3'b000, e.addr, e.data}) begin
                    errors++;
                    $display("[TB] FAIL ram_write: wt=%b rt=%b addr=%h data=%h, required wt=11 rt=000 addr=%h data=%h",
                             bus.ramio_write_type, bus.ramio_read_type, bus.ramio_address, bus.ramio_data_in, e.addr, e.data);
                end
            end
            off = bus.ramio_address - RAM_BASE;
            if (off < 32'(XFER)) ram_mem[int'(off >> 2)] = bus.ramio_data_in;
            lat_kick = 1'b1;
        end
        @(posedge clk);
        #1;
        if (lat_kick) begin
            lat_rem  = ram_lat;
            lat_kick = 1'b0;
        end else if (lat_rem > 0) begin
            lat_rem--;
        end
        lat_busy = (lat_rem > 0);
    end

    function automatic logic [31:0] image_word(input int k);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = flash_mem[(int'(FLASH_BASE) + 4*k + b) % 256];
        return w;
    endfunction

    task automatic launch();
        for (int k = 0; k < WORDS; k++) begin
            wr_t e;
            e.addr = RAM_BASE + 32'(4 * k);
            e.data = image_word(k);
            exp_q.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        #2;
        checks++;
        if ({busy, done, bus.flash_cs, bus.flash_clk, bus.flash_mosi, bus.ramio_enable, bus.ramio_write_type, bus.ramio_read_type} !== 11'b0_0_1_0_0_0_00_000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 00100000000",
                     {busy, done, bus.flash_cs, bus.flash_clk, bus.flash_mosi, bus.ramio_enable, bus.ramio_write_type, bus.ramio_read_type});
        end
        checks++;
        if (bus.ramio_address !== RAM_BASE) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h required %h", bus.ramio_address, RAM_BASE);
        end
        checks++;
        if (bus.ramio_data_in !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h required 0", bus.ramio_data_in);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, bus.flash_cs} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL idle_hold: busy/done/cs=%b required 001", {busy, done, bus.flash_cs});
        end
    endtask

    task automatic test_single_word();
        int base;
        int n;
        bit ok;
        for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
        flash_mem[64] = 8'h37; flash_mem[65] = 8'h01; flash_mem[66] = 8'h01; flash_mem[67] = 8'h00;
        ram_lat  = 0;
        hdr_cmd  = 8'h00;
        hdr_addr = 24'hFFFFFF;
        base     = writes_seen;
        launch();
        n = 1;
        while (bus.ramio_enable !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 129 || n >= 400) begin
            errors++;
            $display("[TB] FAIL first_req_latency: got %0d cycles required >=129", n);
        end
        wait_done(3000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL single_timeout: done=%b required 1", done);
        end
        checks++;
        if (hdr_cmd !== 8'h03 || hdr_addr !== FLASH_BASE) begin
            errors++;
            $display("[TB] FAIL header: cmd=%h addr=%h required cmd=03 addr=%h", hdr_cmd, hdr_addr, FLASH_BASE);
        end
        checks++;
        if (ram_mem[0] !== 32'h00010137) begin
            errors++;
            $display("[TB] FAIL word0: got %h required 00010137", ram_mem[0]);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, bus.flash_cs} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL single_end: done/busy/cs=%b required 101", {done, busy, bus.flash_cs});
        end
        checks++;
        if (writes_seen - base != WORDS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_count: writes=%0d pending=%0d required %0d and 0", writes_seen - base, exp_q.size(), WORDS);
        end
    endtask

    task automatic test_ram_latency();
        bit ok;
        logic [31:0] req [0:3];
        req[0] = 32'h03020100; req[1] = 32'h07060504; req[2] = 32'h0B0A0908; req[3] = 32'h0F0E0D0C;
        for (int i = 0; i < XFER; i++) flash_mem[64 + i] = 8'(i);
        ram_lat = 5;
        launch();
        wait_done(3000, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL latency_run: done=%b pending=%0d required 1 and 0", done, exp_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ram_mem[k] !== req[k]) begin
                errors++;
                $display("[TB] FAIL latency_word%0d: got %h required %h", k, ram_mem[k], req[k]);
            end
        end
        ram_lat = 0;
    endtask

    task automatic test_busy_hold();
        int base;
        int n;
        int viol;
        bit ok;
        ram_lat    = 0;
        force_busy = 1'b1;
        base       = writes_seen;
        launch();
        n = 0;
        while (fl_bits < 64 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fl_bits < 64) begin
            errors++;
            $display("[TB] FAIL hold_word_timeout: bits=%0d required 64", fl_bits);
        end
        repeat (3) @(negedge clk);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.flash_clk !== 1'b0 || bus.flash_cs !== 1'b0 || bus.ramio_enable !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0 || writes_seen != base) begin
            errors++;
            $display("[TB] FAIL hold_quiet: violations=%0d writes=%0d required 0 and 0", viol, writes_seen - base);
        end
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ramio_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: enable=%b required 1", bus.ramio_enable);
        end
        wait_done(3000, ok);
        checks++;
        if (!ok || writes_seen - base != WORDS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL hold_count: done=%b writes=%0d pending=%0d required 1, %0d, 0", done, writes_seen - base, exp_q.size(), WORDS);
        end
    endtask

    task automatic test_reset_abort();
        int base;
        int n;
        bit ok;
        ram_lat = 1;
        base    = writes_seen;
        launch();
        n = 0;
        while ((writes_seen < base + 2 || fl_bits < 108) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("[TB] FAIL abort_reach: writes=%0d bits=%0d required 2 and 108", writes_seen - base, fl_bits);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bus.flash_cs, bus.flash_clk, bus.flash_mosi, bus.ramio_enable, bus.ramio_write_type} !== 8'b0_0_1_0_0_0_00) begin
            errors++;
            $display("[TB] FAIL abort_ctrl: got %b required 00100000",
                     {busy, done, bus.flash_cs, bus.flash_clk, bus.flash_mosi, bus.ramio_enable, bus.ramio_write_type});
        end
        checks++;
        if (bus.ramio_address !== RAM_BASE || bus.ramio_data_in !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_bus: addr=%h data=%h required %h and 0", bus.ramio_address, bus.ramio_data_in, RAM_BASE);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (writes_seen != base + 2) begin
            errors++;
            $display("[TB] FAIL abort_partial: writes=%0d required 2", writes_seen - base);
        end
        hdr_cmd = 8'h00;
        base    = writes_seen;
        launch();
        wait_done(3000, ok);
        checks++;
        if (!ok || hdr_cmd !== 8'h03 || writes_seen - base != WORDS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort_restart: done=%b cmd=%h writes=%0d pending=%0d required 1, 03, %0d, 0",
                     done, hdr_cmd, writes_seen - base, exp_q.size(), WORDS);
        end
        ram_lat = 0;
    endtask

    task automatic test_start_while_busy();
        int base;
        bit ok;
        ram_lat = 2;
        base    = writes_seen;
        launch();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || writes_seen - base != WORDS || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_ignored: done=%b busy=%b writes=%0d pending=%0d required 1, 0, %0d, 0",
                     done, busy, writes_seen - base, exp_q.size(), WORDS);
        end
        ram_lat = 0;
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = writes_seen;
        launch();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_flags: done=%b busy=%b required 0 and 1", done, busy);
        end
        wait_done(3000, ok);
        checks++;
        if (!ok || writes_seen - base != WORDS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL restart_count: done=%b writes=%0d pending=%0d required 1, %0d, 0", done, writes_seen - base, exp_q.size(), WORDS);
        end
    endtask

    task automatic test_full_copy();
        bit ok;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
        for (int k = 0; k < WORDS; k++) ram_mem[k] = 32'hDEAD_BEEF;
        ram_lat    = 3;
        busy_falls = 0;
        launch();
        wait_done(4000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL copy_timeout: done=%b required 1", done);
        end
        for (int k = 0; k < WORDS; k++) begin
            w = image_word(k);
            checks++;
            if (ram_mem[k] !== w) begin
                errors++;
                $display("[TB] FAIL copy_word%0d: got %h required %h", k, ram_mem[k], w);
            end
        end
        checks++;
        if (busy_falls != 1) begin
            errors++;
            $display("[TB] FAIL busy_falls: got %0d required 1", busy_falls);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] flash_loader bench start");
        test_reset();
        test_single_word();
        test_ram_latency();
        test_busy_hold();
        test_reset_abort();
        test_start_while_busy();
        test_back_to_back();
        test_full_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
